// File: rtl/cpu_pkg.sv
// Shared types for the multi-outstanding MEM stage: load opcode encoding,
// the queue entry record and the "no destination" constant.
package cpu_pkg;

  typedef enum logic [2:0] {
    LD_NONE = 3'd0,
    LD_B    = 3'd1,
    LD_BU   = 3'd2,
    LD_H    = 3'd3,
    LD_HU   = 3'd4,
    LD_W    = 3'd5
  } load_op_t;

  // One in-flight instruction. The sideband payload is kept in a parallel
  // array in the stage because its width is a module parameter.
  typedef struct packed {
    logic        valid;
    logic        pend;      // still waiting for its data_ok
    load_op_t    load_op;
    logic [1:0]  addr_lo;
    logic        rf_we;
    logic [4:0]  dest;
    logic [31:0] result;
    logic        ex;
    logic        wr_block;
  } memq_entry_t;

  localparam logic [4:0] MEMQ_DEST_ZERO = 5'd0;

endpackage

// File: rtl/mem_stage_mo_if.sv
// Bus bundle around the MEM stage: pre_MEM handshake, WB handshake,
// forwarding bus, flush and the data-response channel.
// slave = the stage itself, master = its surroundings.
interface mem_stage_mo_if #(
  parameter int DEPTH     = 4,
  parameter int PAYLOAD_W = 96
);
  import cpu_pkg::*;
  localparam int CW = $clog2(DEPTH + 1);

  logic                            pms_valid;
  logic                            ms_allowin;
  logic                            pms_need_data;
  logic                            pms_req_ok;
  load_op_t                        pms_load_op;
  logic [1:0]                      pms_addr_lo;
  logic                            pms_rf_we;
  logic [4:0]                      pms_dest;
  logic [31:0]                     pms_result;
  logic                            pms_ex;
  logic                            pms_wr_block;
  logic [PAYLOAD_W-1:0]            pms_payload;

  logic                            ws_allowin;
  logic                            ms_to_ws_valid;
  logic                            ms_to_ws_rf_we;
  logic [4:0]                      ms_to_ws_dest;
  logic [31:0]                     ms_to_ws_result;
  logic                            ms_to_ws_ex;
  logic [PAYLOAD_W-1:0]            ms_to_ws_payload;

  logic [DEPTH-1:0]                ms_fwd_valid;
  logic [DEPTH-1:0]                ms_fwd_ready;
  logic [DEPTH-1:0][4:0]           ms_fwd_dest;
  logic [DEPTH-1:0][31:0]          ms_fwd_data;
  logic                            ms_wr_disable;
  logic [CW-1:0]                   ms_discard_cnt;

  logic                            flush;
  logic                            data_data_ok;
  logic [31:0]                     data_rdata;

  modport slave (
    input  pms_valid, pms_need_data, pms_req_ok, pms_load_op, pms_addr_lo,
           pms_rf_we, pms_dest, pms_result, pms_ex, pms_wr_block, pms_payload,
           ws_allowin, flush, data_data_ok, data_rdata,
    output ms_allowin, ms_to_ws_valid, ms_to_ws_rf_we, ms_to_ws_dest,
           ms_to_ws_result, ms_to_ws_ex, ms_to_ws_payload, ms_fwd_valid,
           ms_fwd_ready, ms_fwd_dest, ms_fwd_data, ms_wr_disable, ms_discard_cnt
  );

  modport master (
    output pms_valid, pms_need_data, pms_req_ok, pms_load_op, pms_addr_lo,
           pms_rf_we, pms_dest, pms_result, pms_ex, pms_wr_block, pms_payload,
           ws_allowin, flush, data_data_ok, data_rdata,
    input  ms_allowin, ms_to_ws_valid, ms_to_ws_rf_we, ms_to_ws_dest,
           ms_to_ws_result, ms_to_ws_ex, ms_to_ws_payload, ms_fwd_valid,
           ms_fwd_ready, ms_fwd_dest, ms_fwd_data, ms_wr_disable, ms_discard_cnt
  );

endinterface

// File: rtl/mem_load_ext.sv
// Load data alignment: shifts the addressed byte/half down to bit 0 and
// sign- or zero-extends it. Word loads (always aligned) pass through.
module mem_load_ext
  import cpu_pkg::*;
(
  input  load_op_t    load_op,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] rdata,
  output logic [31:0] value
);

  logic [31:0] sh;
  assign sh = rdata >> {addr_lo, 3'b000};

  // extend the shifted lane according to the load type
  always_comb begin
    value = sh;
    case (load_op)
      LD_B:    value = {{24{sh[7]}}, sh[7:0]};
      LD_BU:   value = {24'd0, sh[7:0]};
      LD_H:    value = {{16{sh[15]}}, sh[15:0]};
      LD_HU:   value = {16'd0, sh[15:0]};
      default: value = sh;
    endcase
  end

endmodule

// File: rtl/mem_stage_mo.sv
// Multi-outstanding MEM stage: in-order queue of up to DEPTH instructions
// between pre_MEM and WB. In-order data responses fill the oldest waiting
// entry; entries retire to WB in order. After a flush, responses belonging
// to killed requests are dropped by a counter.
// Optional: MEMQ_BYPASS_EN lets a response that fills the head entry reach
// WB and the slot-0 forward bus in the same cycle.
module mem_stage_mo
  import cpu_pkg::*;
#(
  parameter int DEPTH     = 4,
  parameter int PAYLOAD_W = 96
) (
  input logic          clk,
  input logic          resetn,
  mem_stage_mo_if.slave bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  memq_entry_t [DEPTH-1:0]                q;
  logic        [DEPTH-1:0][PAYLOAD_W-1:0] pay;
  logic [AW-1:0] head, tail, fill_idx, scan_idx;
  logic [CW-1:0] count, discard_cnt, n_wait, disc_flush;
  logic [CW:0]   outstanding, disc_sum;
  logic          fill_hit, fill, pop, push, allowin, req_in;
  logic          head_done;
  logic [31:0]   ext_val, fill_val, head_result;
  memq_entry_t   head_e, new_e;

  assign head_e = q[head];

  // count waiting entries and find the oldest one, scanning from head
  always_comb begin
    n_wait   = '0;
    fill_hit = 1'b0;
    fill_idx = head;
    scan_idx = head;
    for (int i = 0; i < DEPTH; i++) begin
      n_wait   = n_wait + CW'(q[i].valid && q[i].pend);
      scan_idx = head + AW'(i);
      if (!fill_hit && q[scan_idx].valid && q[scan_idx].pend) begin
        fill_hit = 1'b1;
        fill_idx = scan_idx;
      end
    end
  end

  mem_load_ext u_ext (
    .load_op (q[fill_idx].load_op),
    .addr_lo (q[fill_idx].addr_lo),
    .rdata   (bus.data_rdata),
    .value   (ext_val)
  );

  // stores keep their address/result; loads take the aligned data
  assign fill_val = (q[fill_idx].load_op == LD_NONE) ? q[fill_idx].result : ext_val;
  assign fill     = bus.data_data_ok && (discard_cnt == '0) && fill_hit;

`ifdef MEMQ_BYPASS_EN
  logic byp;
  assign byp         = fill && (fill_idx == head);
  assign head_done   = (head_e.valid && !head_e.pend) || byp;
  assign head_result = byp ? fill_val : head_e.result;
`else
  assign head_done   = head_e.valid && !head_e.pend;
  assign head_result = head_e.result;
`endif

  assign outstanding = {1'b0, discard_cnt} + {1'b0, n_wait};
  assign pop     = head_done && bus.ws_allowin && !bus.flush;
  assign allowin = ((count < CW'(DEPTH)) || pop) && (outstanding < (CW+1)'(DEPTH));
  assign push    = bus.pms_valid && allowin && !bus.flush;
  assign req_in  = bus.pms_valid && bus.pms_req_ok && bus.pms_need_data && allowin;

  // stale responses after flush: every live request plus the one issued
  // this cycle, minus a response landing in the flush cycle itself
  assign disc_sum   = {1'b0, discard_cnt} + {1'b0, n_wait} + (CW+1)'(req_in);
  assign disc_flush = CW'(disc_sum - (CW+1)'(bus.data_data_ok && (disc_sum != '0)));

  // entry image written at tail on push
  always_comb begin
    new_e          = '0;
    new_e.valid    = 1'b1;
    new_e.pend     = bus.pms_need_data && !bus.pms_ex;
    new_e.load_op  = bus.pms_load_op;
    new_e.addr_lo  = bus.pms_addr_lo;
    new_e.rf_we    = bus.pms_rf_we;
    new_e.dest     = bus.pms_dest;
    new_e.result   = bus.pms_result;
    new_e.ex       = bus.pms_ex;
    new_e.wr_block = bus.pms_wr_block;
  end

  // queue state: flush beats fill/pop/push; push is applied last so a
  // full queue popping and pushing in one cycle reuses the head slot
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      q           <= '0;
      head        <= '0;
      tail        <= '0;
      count       <= '0;
      discard_cnt <= '0;
    end else if (bus.flush) begin
      q           <= '0;
      head        <= '0;
      tail        <= '0;
      count       <= '0;
      discard_cnt <= disc_flush;
    end else begin
      if (bus.data_data_ok && (discard_cnt != '0))
        discard_cnt <= discard_cnt - CW'(1);
      if (fill) begin
        q[fill_idx].result <= fill_val;
        q[fill_idx].pend   <= 1'b0;
      end
      if (pop) begin
        q[head].valid <= 1'b0;
        head          <= head + AW'(1);
      end
      if (push) begin
        q[tail] <= new_e;
        tail    <= tail + AW'(1);
      end
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // sideband storage, qualified by the entry valid bit so no reset needed
  always_ff @(posedge clk) begin
    if (push) pay[tail] <= bus.pms_payload;
  end

  // forwarding bus, oldest first; slot 0 follows the head view
  always_comb begin
    bus.ms_fwd_valid = '0;
    bus.ms_fwd_ready = '0;
    bus.ms_fwd_dest  = '0;
    bus.ms_fwd_data  = '0;
    for (int k = 0; k < DEPTH; k++) begin
      bus.ms_fwd_valid[k] = q[head + AW'(k)].valid;
      bus.ms_fwd_ready[k] = q[head + AW'(k)].valid && !q[head + AW'(k)].pend;
      bus.ms_fwd_dest[k]  = (q[head + AW'(k)].valid && q[head + AW'(k)].rf_we)
                            ? q[head + AW'(k)].dest : MEMQ_DEST_ZERO;
      bus.ms_fwd_data[k]  = q[head + AW'(k)].result;
    end
    bus.ms_fwd_ready[0] = head_done;
    bus.ms_fwd_data[0]  = head_result;
  end

  // any live exception/eret blocks younger side effects
  always_comb begin
    bus.ms_wr_disable = 1'b0;
    for (int k = 0; k < DEPTH; k++)
      bus.ms_wr_disable = bus.ms_wr_disable | (q[k].valid && q[k].wr_block);
  end

  assign bus.ms_allowin       = allowin;
  // a flushed head must not be taken by WB
  assign bus.ms_to_ws_valid   = head_done && !bus.flush;
  assign bus.ms_to_ws_rf_we   = head_e.rf_we;
  assign bus.ms_to_ws_dest    = head_e.dest;
  assign bus.ms_to_ws_result  = head_result;
  assign bus.ms_to_ws_ex      = head_e.ex;
  assign bus.ms_to_ws_payload = pay[head];
  assign bus.ms_discard_cnt   = discard_cnt;

  // a response with nothing to fill and nothing to discard is a protocol error
  a_no_orphan_rsp: assert property (@(posedge clk) disable iff (!resetn)
    bus.data_data_ok |-> ((discard_cnt != '0) || fill_hit));

endmodule

// File: tb/tb_mem_stage_mo.sv
// Directed bench for mem_stage_mo (DEPTH=4). Expected values are hand
// computed; latency checks follow MEMQ_BYPASS_EN if the build defines it.
module tb_mem_stage_mo;
  import cpu_pkg::*;

  logic clk;
  logic resetn;
  int   vecs  = 0;
  int   fails = 0;

  mem_stage_mo_if #(.DEPTH(4), .PAYLOAD_W(96)) bus ();

  mem_stage_mo #(.DEPTH(4), .PAYLOAD_W(96)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vecs++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input load_op_t op, input logic [1:0] lo, input logic nd,
                      input logic [4:0] dest, input logic [31:0] res, input logic wb);
    bus.pms_valid     = 1'b1;
    bus.pms_load_op   = op;
    bus.pms_addr_lo   = lo;
    bus.pms_need_data = nd;
    bus.pms_req_ok    = nd;
    bus.pms_rf_we     = (dest != 5'd0);
    bus.pms_dest      = dest;
    bus.pms_result    = res;
    bus.pms_wr_block  = wb;
    bus.pms_payload   = {res, ~res, res};
    tick();
    bus.pms_valid     = 1'b0;
    bus.pms_need_data = 1'b0;
    bus.pms_req_ok    = 1'b0;
    bus.pms_wr_block  = 1'b0;
  endtask

  // one response to a waiting head with ws_allowin=1; ends after the head pops
  task automatic respond(input string tag, input logic [31:0] rd,
                         input logic [31:0] exp, input logic [4:0] edest);
    bus.data_data_ok = 1'b1;
    bus.data_rdata   = rd;
    #1;
`ifdef MEMQ_BYPASS_EN
    chk({tag, ".valid_same_cycle"}, bus.ms_to_ws_valid, 1'b1);
    chk({tag, ".result"}, bus.ms_to_ws_result, exp);
    chk({tag, ".dest"}, bus.ms_to_ws_dest, edest);
    tick();
    bus.data_data_ok = 1'b0;
`else
    chk({tag, ".valid_same_cycle"}, bus.ms_to_ws_valid, 1'b0);
    tick();
    bus.data_data_ok = 1'b0;
    #1;
    chk({tag, ".valid_next_cycle"}, bus.ms_to_ws_valid, 1'b1);
    chk({tag, ".result"}, bus.ms_to_ws_result, exp);
    chk({tag, ".dest"}, bus.ms_to_ws_dest, edest);
    tick();
`endif
  endtask

  task automatic load_one(input string tag, input load_op_t op, input logic [1:0] lo,
                          input logic [31:0] res, input logic [31:0] rd,
                          input logic [31:0] exp);
    push(op, lo, 1'b1, 5'd3, res, 1'b0);
    respond(tag, rd, exp, 5'd3);
  endtask

  initial begin
    resetn = 1'b0;
    bus.pms_valid = 1'b0; bus.pms_need_data = 1'b0; bus.pms_req_ok = 1'b0;
    bus.pms_load_op = LD_NONE; bus.pms_addr_lo = 2'd0; bus.pms_rf_we = 1'b0;
    bus.pms_dest = 5'd0; bus.pms_result = 32'd0; bus.pms_ex = 1'b0;
    bus.pms_wr_block = 1'b0; bus.pms_payload = '0; bus.ws_allowin = 1'b1;
    bus.flush = 1'b0; bus.data_data_ok = 1'b0; bus.data_rdata = 32'd0;
    #1;
    chk("rst.allowin", bus.ms_allowin, 1'b1);
    chk("rst.to_ws_valid", bus.ms_to_ws_valid, 1'b0);
    chk("rst.fwd_valid", bus.ms_fwd_valid, 4'b0000);
    chk("rst.wr_disable", bus.ms_wr_disable, 1'b0);
    chk("rst.discard", bus.ms_discard_cnt, 3'd0);
    tick();
    resetn = 1'b1;
    tick();

    // four LW fill the queue and the outstanding limit
    push(LD_W, 2'd0, 1'b1, 5'd1, 32'h100, 1'b0);
    push(LD_W, 2'd0, 1'b1, 5'd2, 32'h104, 1'b0);
    push(LD_W, 2'd0, 1'b1, 5'd3, 32'h108, 1'b0);
    #1;
    chk("lw4.allowin_at3", bus.ms_allowin, 1'b1);
    push(LD_W, 2'd0, 1'b1, 5'd4, 32'h10c, 1'b0);
    #1;
    chk("lw4.allowin_full", bus.ms_allowin, 1'b0);
    chk("lw4.fwd_valid", bus.ms_fwd_valid, 4'b1111);
    chk("lw4.fwd_ready", bus.ms_fwd_ready, 4'b0000);
    chk("lw4.fwd_dest", bus.ms_fwd_dest, {5'd4, 5'd3, 5'd2, 5'd1});
    respond("lw4.r1", 32'h11, 32'h11, 5'd1);
    respond("lw4.r2", 32'h22, 32'h22, 5'd2);
    respond("lw4.r3", 32'h33, 32'h33, 5'd3);
    respond("lw4.r4", 32'h44, 32'h44, 5'd4);
    #1;
    chk("lw4.empty_valid", bus.ms_to_ws_valid, 1'b0);
    chk("lw4.empty_fwd", bus.ms_fwd_valid, 4'b0000);
    chk("lw4.empty_allowin", bus.ms_allowin, 1'b1);

    // alignment and extension
    load_one("ext.lb3",  LD_B,    2'd3, 32'h203, 32'h80FF_FFFF, 32'hFFFF_FF80);
    load_one("ext.lbu3", LD_BU,   2'd3, 32'h203, 32'h80FF_FFFF, 32'h0000_0080);
    load_one("ext.lh2",  LD_H,    2'd2, 32'h202, 32'h7FFF_0000, 32'h0000_7FFF);
    load_one("ext.lhu2", LD_HU,   2'd2, 32'h202, 32'h8000_1234, 32'h0000_8000);
    load_one("ext.lh0",  LD_H,    2'd0, 32'h200, 32'h0000_8001, 32'hFFFF_8001);
    load_one("ext.lb1",  LD_B,    2'd1, 32'h201, 32'h0000_7F00, 32'h0000_007F);
    load_one("ext.lw",   LD_W,    2'd0, 32'h200, 32'hCAFE_BABE, 32'hCAFE_BABE);
    load_one("ext.st",   LD_NONE, 2'd0, 32'h300, 32'hFFFF_FFFF, 32'h0000_0300);

    // ALU op behind a waiting load must not overtake it
    bus.ws_allowin = 1'b0;
    push(LD_W, 2'd0, 1'b1, 5'd8, 32'h400, 1'b0);
    push(LD_NONE, 2'd0, 1'b0, 5'd9, 32'h1234, 1'b0);
    #1;
    chk("ord.fwd_valid", bus.ms_fwd_valid, 4'b0011);
    chk("ord.fwd_ready", bus.ms_fwd_ready, 4'b0010);
    chk("ord.fwd_dest", bus.ms_fwd_dest, {5'd0, 5'd0, 5'd9, 5'd8});
    chk("ord.fwd_data1", bus.ms_fwd_data[1], 32'h1234);
    chk("ord.valid_wait", bus.ms_to_ws_valid, 1'b0);
    bus.data_data_ok = 1'b1;
    bus.data_rdata   = 32'h5555;
    tick();
    bus.data_data_ok = 1'b0;
    #1;
    chk("ord.head_valid", bus.ms_to_ws_valid, 1'b1);
    chk("ord.head_result", bus.ms_to_ws_result, 32'h5555);
    chk("ord.fwd_ready2", bus.ms_fwd_ready, 4'b0011);
    tick();
    chk("ord.hold_dest", bus.ms_to_ws_dest, 5'd8);
    bus.ws_allowin = 1'b1;
    tick();
    chk("ord.alu_dest", bus.ms_to_ws_dest, 5'd9);
    chk("ord.alu_result", bus.ms_to_ws_result, 32'h1234);
    chk("ord.alu_payload", bus.ms_to_ws_payload, {32'h1234, ~32'h1234, 32'h1234});
    tick();
    chk("ord.drained", bus.ms_to_ws_valid, 1'b0);

    // flush with one response and one new request in the same cycle
    push(LD_W, 2'd0, 1'b1, 5'd5, 32'h500, 1'b1);
    push(LD_W, 2'd0, 1'b1, 5'd6, 32'h504, 1'b0);
    #1;
    chk("fl.wr_disable", bus.ms_wr_disable, 1'b1);
    chk("fl.allowin", bus.ms_allowin, 1'b1);
    bus.flush = 1'b1;
    bus.data_data_ok = 1'b1;
    bus.data_rdata = 32'h9999;
    bus.pms_valid = 1'b1; bus.pms_need_data = 1'b1; bus.pms_req_ok = 1'b1;
    bus.pms_load_op = LD_W; bus.pms_dest = 5'd10;
    #1;
    chk("fl.to_ws_gated", bus.ms_to_ws_valid, 1'b0);
    tick();
    bus.flush = 1'b0; bus.data_data_ok = 1'b0;
    bus.pms_valid = 1'b0; bus.pms_need_data = 1'b0; bus.pms_req_ok = 1'b0;
    #1;
    chk("fl.discard2", bus.ms_discard_cnt, 3'd2);
    chk("fl.fwd_valid", bus.ms_fwd_valid, 4'b0000);
    chk("fl.wr_disable_clr", bus.ms_wr_disable, 1'b0);
    push(LD_W, 2'd0, 1'b1, 5'd7, 32'h600, 1'b0);
    #1;
    chk("fl.new_valid", bus.ms_fwd_valid, 4'b0001);
    bus.data_data_ok = 1'b1; bus.data_rdata = 32'hDEAD;
    tick();
    chk("fl.discard1", bus.ms_discard_cnt, 3'd1);
    bus.data_rdata = 32'hBEEF;
    #1;
    chk("fl.drop_no_valid", bus.ms_to_ws_valid, 1'b0);
    tick();
    bus.data_data_ok = 1'b0;
    #1;
    chk("fl.discard0", bus.ms_discard_cnt, 3'd0);
    chk("fl.still_wait", bus.ms_fwd_ready, 4'b0000);
    respond("fl.fill", 32'hCAFE, 32'hCAFE, 5'd7);

    // asynchronous reset mid-operation with three waiting entries
    push(LD_W, 2'd0, 1'b1, 5'd1, 32'h700, 1'b0);
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    push(LD_W, 2'd0, 1'b1, 5'd2, 32'h704, 1'b0);
    push(LD_W, 2'd0, 1'b1, 5'd3, 32'h708, 1'b1);
    push(LD_W, 2'd0, 1'b1, 5'd4, 32'h70c, 1'b0);
    #1;
    chk("mr.pre_allowin", bus.ms_allowin, 1'b0);
    chk("mr.pre_fwd", bus.ms_fwd_valid, 4'b0111);
    chk("mr.pre_discard", bus.ms_discard_cnt, 3'd1);
    #1;
    resetn = 1'b0;
    #1;
    chk("mr.allowin", bus.ms_allowin, 1'b1);
    chk("mr.to_ws_valid", bus.ms_to_ws_valid, 1'b0);
    chk("mr.discard", bus.ms_discard_cnt, 3'd0);
    chk("mr.fwd_valid", bus.ms_fwd_valid, 4'b0000);
    chk("mr.wr_disable", bus.ms_wr_disable, 1'b0);
    resetn = 1'b1;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
    $finish;
  end

endmodule

// File: doc/mem_stage_mo.md
Name: mem_stage_mo

Overview:
- Multi-outstanding successor of the single-entry MEM stage. It sits between pre_MEM and WB and holds up to DEPTH in-flight instructions in an in-order queue.
- Memory responses (data_data_ok) are matched to the oldest waiting entry.
- Loads are aligned and extended, and entries retire to WB in order.
- After a pipeline flush, stale responses are discarded by counter instead of a single cancel flag.

Parameters:
- DEPTH, 4, queue entries and max outstanding data requests (power of two, >=2)
- PAYLOAD_W, 96, opaque sideband width (pc, c0/tlb/cache ops, exception code, phy_addr), passed through untouched

Ports:
- clk  in  1  clock
- resetn  in  1  asynchronous active-low reset
- pms_valid  in  1  pre_MEM offers an instruction
- ms_allowin  out  1  stage accepts an instruction this cycle
- pms_need_data  in  1  instruction issued a data request (load or store) and expects one data_ok
- pms_req_ok  in  1  request was accepted by memory; must be 1 whenever pms_need_data=1 on push
- pms_load_op  in  3  0 none, 1 LB, 2 LBU, 3 LH, 4 LHU, 5 LW
- pms_addr_lo  in  2  address bits [1:0]
- pms_rf_we  in  1  register write enable
- pms_dest  in  5  destination register
- pms_result  in  32  ALU result / store address
- pms_ex  in  1  exception raised; entry never waits for data
- pms_wr_block  in  1  exception or eret; blocks later CP0/store side effects
- pms_payload  in  PAYLOAD_W  sideband
- ws_allowin  in  1  WB accepts
- ms_to_ws_valid  out  1  head entry is complete
- ms_to_ws_rf_we  out  1  head entry register write enable
- ms_to_ws_dest  out  5  head entry destination
- ms_to_ws_result  out  32  head entry final result
- ms_to_ws_ex  out  1  head entry exception flag
- ms_to_ws_payload  out  PAYLOAD_W  head entry sideband
- ms_fwd_valid  out  DEPTH  slot k valid (slot 0 = oldest)
- ms_fwd_ready  out  DEPTH  slot k value final
- ms_fwd_dest  out  5*DEPTH  per-slot dest; 0 if slot invalid or rf_we=0
- ms_fwd_data  out  32*DEPTH  per-slot final result
- ms_wr_disable  out  1  OR over valid entries of wr_block
- ms_discard_cnt  out  $clog2(DEPTH+1)  stale responses still to drop
- flush  in  1  pipeline flush
- data_data_ok  in  1  in-order data response
- data_rdata  in  32  response data

Behaviour:
- Reset (resetn=0, asynchronous): all entries invalid; head, tail, count and discard_cnt = 0. Outputs: ms_allowin=1, ms_to_ws_valid=0, ms_fwd_valid=0, ms_wr_disable=0, ms_discard_cnt=0.
- Storage: circular buffer. Entry holds valid, wait, load_op, addr_lo, rf_we, dest, result, ex, wr_block, payload. count width $clog2(DEPTH+1); pointers wrap mod DEPTH.
- push = pms_valid && ms_allowin && !flush. Entry written at tail with wait = pms_need_data && !pms_ex.
- outstanding = discard_cnt + number of waiting entries.
- ms_allowin = (count<DEPTH || pop) && outstanding<DEPTH. Pushes without a data request are also blocked while the limit is reached.
- Response handling when data_data_ok=1:
  - discard_cnt>0: decrement discard_cnt and drop data.
  - Otherwise: fill the oldest valid entry with wait=1. Store the extracted value in result and clear wait.
  - No waiting entry and discard_cnt=0: protocol violation; ignore and fire a simulation assertion.
- Load extraction: byte/half = data_rdata >> 8*addr_lo, sign- or zero-extended; LW passes the word through. Unaligned half/word is never presented (already excepted upstream). Stores (load_op=0) leave result unchanged.
- Head complete when valid && !wait. pop = complete && ws_allowin. Head advances; the next entry is visible the following cycle.
- Simultaneous push and pop: count unchanged.
- Flush (wins over push/pop/fill; registered, effective next cycle):
  - All entries invalid; pointers and count = 0.
  - discard_cnt_next = discard_cnt + waiting_entries + (pms_valid && pms_req_ok && pms_need_data && ms_allowin) - data_data_ok. This never exceeds DEPTH by the allowin rule.
  - The entry offered in the flush cycle is dropped.
- ms_wr_disable is combinational from entry state; it reads 0 in the cycle after flush.
- Forward bus is ordered oldest-first. ready = valid && !wait.

Optional Feature:
- Macro MEMQ_BYPASS_EN.
- Defined: when data_data_ok fills the head entry (discard_cnt=0), the head is complete in the same cycle. ms_to_ws_result and ms_fwd_data[slot0] take the extracted data_rdata combinationally, and the head pops if ws_allowin. Load-to-WB latency is 0 cycles after data_ok.
- Undefined: the fill is registered and the head becomes complete the next cycle (latency 1). No combinational path from data_rdata to outputs.

Decomposition:
- Shared package cpu_pkg:
  - load_op_t enum (LD_NONE, LD_B, LD_BU, LD_H, LD_HU, LD_W)
  - memq_entry_t struct
  - MEMQ_DEST_ZERO constant
- One sub-module: mem_load_ext, combinational align/extend: load_op, addr_lo, rdata -> 32-bit value.

Test Plan:
- Reset mid-operation with 3 waiting entries -> ms_to_ws_valid=0, ms_allowin=1, discard_cnt=0 immediately while resetn=0.
- Push 4 LW (DEPTH=4). Return data_ok with 0x11,0x22,0x33,0x44 while ws_allowin=1 -> WB sees 0x11..0x44 in order. ms_allowin=0 while 4 are outstanding.
- LB at addr_lo=3 with rdata=0x80FF_FFFF -> result 0xFFFF_FF80. LBU -> 0x0000_0080. LH at addr_lo=2 with rdata=0x7FFF_0000 -> 0x0000_7FFF.
- 2 loads outstanding, flush in the same cycle as one data_ok plus a new pushed request -> discard_cnt=2. The next 2 data_ok are dropped; the third fills the new load.
- ALU op behind a waiting load with ws_allowin=0 -> no reordering. ALU retires only after the load pops; ms_fwd_ready=2'b10 before data arrives.
- ws_allowin=1 and data_ok fills head -> with MEMQ_BYPASS_EN, ms_to_ws_valid=1 in the same cycle; without it, ms_to_ws_valid=1 one cycle later.
